// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and talks to a variable-latency instruction memory through a
// req/ready handshake. The IF/ID outputs are fully registered.
//
// Memory handshake: imem_req/imem_addr are asserted by this block, and
// imem_addr stays stable until a cycle in which imem_ready=1. That cycle
// completes the transfer and imem_rdata is valid in it. A request is never
// withdrawn. Decode-side hold/flush is controlled by freeze and branch_taken.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instruction,
    output logic        valid,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_redirect_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_pc_out_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;

    // Sequential PC increment wraps naturally at 2^32; branch targets are
    // forced word-aligned.
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = branch_address & 32'hFFFF_FFFC;

    assign imem_req    = (r_state != S_HOLD);
    assign imem_addr   = r_pc;
    assign PC_out      = r_pc_out;
    assign instruction = r_instr;
    assign valid       = r_valid;
    assign o_dbg_state = r_state;

    // Next-state, PC, skid and IF/ID update; flush beats freeze beats advance.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_redirect_nxt   = r_redirect;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_pc_out_nxt     = r_pc_out;
        w_instr_nxt      = r_instr;
        w_valid_nxt      = r_valid;

        case (r_state)
            S_FETCH: begin
                if (branch_taken) begin
                    // Flush: whatever is in flight is not delivered to decode.
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                    if (imem_ready) begin
                        w_pc_nxt = w_br_target;
                    end else begin
                        // Request cannot be aborted, so wait it out in DRAIN.
                        w_redirect_nxt = w_br_target;
                        w_state_nxt    = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    w_pc_nxt = w_pc_plus4;
                    if (freeze) begin
                        // Decode cannot take the word yet; park it.
                        w_skid_pc_nxt    = w_pc_plus4;
                        w_skid_instr_nxt = imem_rdata;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_pc_out_nxt = w_pc_plus4;
                        w_instr_nxt  = imem_rdata;
                        w_valid_nxt  = 1'b1;
                    end
                end else if (!freeze) begin
                    // Memory wait state: feed decode a bubble.
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end
            end

            S_DRAIN: begin
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
                if (imem_ready) begin
                    // A redirect arriving in the completing cycle still wins.
                    w_pc_nxt    = branch_taken ? w_br_target : r_redirect;
                    w_state_nxt = S_FETCH;
                end else if (branch_taken) begin
                    w_redirect_nxt = w_br_target;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = w_br_target;
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FETCH;
                end else if (!freeze) begin
                    w_pc_out_nxt = r_skid_pc;
                    w_instr_nxt  = r_skid_instr;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State, PC, redirect, skid and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_redirect   <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
            r_pc_out     <= 32'd0;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redirect   <= w_redirect_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_instr      <= w_instr_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed cycle scenarios with a scoreboard of
// expected IF/ID contents. Instance dut_a uses the default reset PC, dut_b
// uses 32'hFFFF_FFFC for the wrap-around case.
module tb_if_stage_fetch;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        a_req, b_req, a_valid, b_valid;
    logic [31:0] a_addr, b_addr, a_pc_out, b_pc_out, a_instr, b_instr;
    logic [1:0]  a_state, b_state;

    logic        use_b;
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc_out, obs_instr;

    logic [64:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          step_no;

    if_stage_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut_a (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_out(a_pc_out),
        .instruction(a_instr), .valid(a_valid), .o_dbg_state(a_state)
    );

    if_stage_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_b (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_out(b_pc_out),
        .instruction(b_instr), .valid(b_valid), .o_dbg_state(b_state)
    );

    always_comb begin
        obs_req    = use_b ? b_req    : a_req;
        obs_addr   = use_b ? b_addr   : a_addr;
        obs_pc_out = use_b ? b_pc_out : a_pc_out;
        obs_instr  = use_b ? b_instr  : a_instr;
        obs_valid  = use_b ? b_valid  : a_valid;
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Hold reset for n cycles, then check the reset image of IF/ID and PC.
    task automatic do_reset(input int n, input logic [31:0] exp_addr);
        rst = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_valid", 32'(obs_valid), 32'd0);
        check_eq("rst_instr", obs_instr, NOP);
        check_eq("rst_pc_out", obs_pc_out, 32'd0);
        check_eq("rst_req", 32'(obs_req), 32'd1);
        check_eq("rst_addr", obs_addr, exp_addr);
    endtask

    // One clock of stimulus: checks the request seen this cycle, queues the
    // IF/ID image expected after the edge, then pops and compares it.
    task automatic step(input logic fz, input logic bt, input logic [31:0] ba,
                        input logic rdy, input logic [31:0] rd,
                        input logic e_req, input logic [31:0] e_addr,
                        input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_ins);
        logic [64:0] exp;
        step_no++;
        freeze = fz; branch_taken = bt; branch_address = ba;
        imem_ready = rdy; imem_rdata = rd;
        #1;
        check_eq($sformatf("s%0d_req", step_no), 32'(obs_req), 32'(e_req));
        if (e_req) check_eq($sformatf("s%0d_addr", step_no), obs_addr, e_addr);
        exp_q.push_back({e_v, e_pc, e_ins});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_eq($sformatf("s%0d_valid", step_no), 32'(obs_valid), 32'(exp[64]));
        check_eq($sformatf("s%0d_pc_out", step_no), obs_pc_out, exp[63:32]);
        check_eq($sformatf("s%0d_instr", step_no), obs_instr, exp[31:0]);
    endtask

    initial begin
        logic [31:0] w [4];
        n_checks = 0; n_pass = 0; step_no = 0; use_b = 1'b0;
        rst = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        @(posedge clk); #1;

        // Zero-wait sequential fetch
        do_reset(2, 32'h0);
        for (int i = 0; i < 4; i++) w[i] = $urandom_range(32'h7FFF_FFFF, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, w[i], 1, 32'(4 * i), 1, 32'(4 * i + 4), w[i]);

        // Wait states at address 0
        do_reset(1, 32'h0);
        step(0, 0, 0, 0, 32'hDEAD_0001, 1, 32'h0, 0, 32'h0, NOP);
        step(0, 0, 0, 0, 32'hDEAD_0002, 1, 32'h0, 0, 32'h0, NOP);
        step(0, 0, 0, 1, 32'hE3A0_1005, 1, 32'h0, 1, 32'h4, 32'hE3A0_1005);

        // Freeze with skid on the fetch at 8
        step(0, 0, 0, 1, 32'h2222_2222, 1, 32'h4, 1, 32'h8, 32'h2222_2222);
        step(1, 0, 0, 1, 32'h1111_1111, 1, 32'h8, 1, 32'h8, 32'h2222_2222);
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8, 32'h2222_2222);
        step(1, 0, 0, 1, 32'hBAD0_0000, 0, 32'h0, 1, 32'h8, 32'h2222_2222);
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'hC, 32'h1111_1111);
        step(0, 0, 0, 0, 32'h0, 1, 32'hC, 0, 32'hC, NOP);

        // Branch while the fetch at 0x10 is pending
        step(0, 0, 0, 1, 32'h3333_3333, 1, 32'hC, 1, 32'h10, 32'h3333_3333);
        step(0, 1, 32'h40, 0, 32'h0, 1, 32'h10, 0, 32'h10, NOP);
        step(0, 0, 0, 0, 32'h0, 1, 32'h10, 0, 32'h10, NOP);
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h10, 0, 32'h10, NOP);
        step(0, 0, 0, 1, 32'h4444_4444, 1, 32'h40, 1, 32'h44, 32'h4444_4444);

        // Repeated redirects while draining: newest wins, low bits dropped
        step(0, 1, 32'h80, 0, 32'h0, 1, 32'h44, 0, 32'h44, NOP);
        step(0, 1, 32'h203, 0, 32'h0, 1, 32'h44, 0, 32'h44, NOP);
        step(0, 0, 0, 1, 32'hBAD0_0001, 1, 32'h44, 0, 32'h44, NOP);
        step(0, 0, 0, 1, 32'h5555_5555, 1, 32'h200, 1, 32'h204, 32'h5555_5555);

        // Branch in the same cycle the fetch completes: word dropped
        step(0, 1, 32'h300, 1, 32'hBAD0_0002, 1, 32'h204, 0, 32'h204, NOP);
        step(0, 0, 0, 1, 32'h6666_6666, 1, 32'h300, 1, 32'h304, 32'h6666_6666);

        // Branch and freeze together in HOLD: skid discarded
        step(1, 0, 0, 1, 32'h7777_7777, 1, 32'h304, 1, 32'h304, 32'h6666_6666);
        step(1, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h304, NOP);
        step(0, 0, 0, 1, 32'h8888_8888, 1, 32'h100, 1, 32'h104, 32'h8888_8888);
        step(1, 0, 0, 0, 32'h0, 1, 32'h104, 1, 32'h104, 32'h8888_8888);

        // PC wrap from 32'hFFFF_FFFC, then reset mid-run
        use_b = 1'b1;
        do_reset(2, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 32'h0B0B_0B0B, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h0B0B_0B0B);
        step(0, 0, 0, 1, 32'h0C0C_0C0C, 1, 32'h0, 1, 32'h4, 32'h0C0C_0C0C);
        do_reset(1, 32'hFFFF_FFFC);

        if (exp_q.size() != 0) check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
